// File: rtl/axi_slave_ram_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_slave_ram_burst
// Purpose  : AXI4 memory-mapped slave backed by an inferred byte-writable RAM.
//            Independent read and write engines with FIXED/INCR/WRAP bursts,
//            byte strobes, ID echo and SLVERR reporting.
// Revision : 1.0 - initial release
// ============================================================================
module axi_slave_ram_burst #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    // write address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    // write response channel
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    // ------------------------------------------------------------------------
    // Derived constants. The word address keeps only the bits above the byte
    // lane offset; the WRAP mask below assumes at least 5 word-address bits.
    // ------------------------------------------------------------------------
    localparam int C_STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int C_LSB    = $clog2(C_STRB_W);
    localparam int C_WA_W   = C_S_AXI_ADDR_WIDTH - C_LSB;
    localparam int C_DEPTH  = 2 ** C_WA_W;

    localparam logic [C_WA_W-1:0] C_WORD_ONE = {{(C_WA_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [1:0] C_BURST_WRAP  = 2'b10;
    localparam logic [1:0] C_BURST_RESV  = 2'b11;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // ------------------------------------------------------------------------
    // Burst address sequencing shared by both engines. WRAP keeps the upper
    // bits and increments only inside a (len+1)-word aligned window; legal
    // WRAP lengths are 2^k-1 so len itself is the window mask.
    // ------------------------------------------------------------------------
    function automatic logic [C_WA_W-1:0] f_next_addr(
        input logic [C_WA_W-1:0] addr,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [C_WA_W-1:0] mask;
        logic [C_WA_W-1:0] inc;
        logic [C_WA_W-1:0] result;
        mask = {{(C_WA_W-4){1'b0}}, len[3:0]};
        inc  = addr + C_WORD_ONE;
        case (burst)
            C_BURST_FIXED: result = addr;
            C_BURST_WRAP:  result = (addr & ~mask) | (inc & mask);
            default:       result = inc;
        endcase
        return result;
    endfunction

    // Reserved burst type and WRAP with a non power-of-two beat count are errors.
    function automatic logic f_burst_ok(
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic ok;
        ok = 1'b1;
        if (burst == C_BURST_RESV) begin
            ok = 1'b0;
        end else if (burst == C_BURST_WRAP &&
                     !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------------
    // Write engine state
    // ------------------------------------------------------------------------
    w_state_t                    w_state_q, w_state_d;
    logic                        awready_q, awready_d;
    logic                        wready_q,  wready_d;
    logic                        bvalid_q,  bvalid_d;
    logic [C_S_AXI_ID_WIDTH-1:0] bid_q,     bid_d;
    logic [1:0]                  bresp_q,   bresp_d;
    logic [C_WA_W-1:0]           w_addr_q,  w_addr_d;
    logic [7:0]                  w_len_q,   w_len_d;
    logic [1:0]                  w_burst_q, w_burst_d;
    logic [7:0]                  w_cnt_q,   w_cnt_d;
    logic                        w_err_q,   w_err_d;
    logic                        w_skip_q,  w_skip_d;

    logic                        w_hs;
    logic                        w_last_beat;
    logic                        w_last_bad;
    logic                        aw_ok;
    logic                        ram_we;

    assign w_hs        = S_AXI_WVALID && wready_q;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_last_bad  = (S_AXI_WLAST != w_last_beat);
    assign aw_ok       = f_burst_ok(S_AXI_AWBURST, S_AXI_AWLEN);

    // Write engine next-state: capture AW, stream W beats into RAM, issue B.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_skip_d  = w_skip_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID) begin
                    bid_d     = S_AXI_AWID;
                    w_addr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_LSB];
                    w_len_d   = S_AXI_AWLEN;
                    w_burst_d = S_AXI_AWBURST;
                    w_cnt_d   = 8'd0;
                    w_err_d   = !aw_ok;
                    w_skip_d  = !aw_ok;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Illegal-burst writes still consume beats but never touch RAM.
                    ram_we   = !w_skip_q;
                    w_addr_d = f_next_addr(w_addr_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last_bad) begin
                        w_err_d = 1'b1;
                    end
                    // The beat count, not WLAST, decides where the burst ends.
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_last_bad) ? C_RESP_SLVERR : C_RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write engine registers; reset aborts any burst in flight.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= C_RESP_OKAY;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            w_skip_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_skip_q  <= w_skip_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read engine state. r_addr_q always holds the word currently on RDATA.
    // ------------------------------------------------------------------------
    r_state_t                    r_state_q, r_state_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q,  rvalid_d;
    logic                        rlast_q,   rlast_d;
    logic [C_S_AXI_ID_WIDTH-1:0] rid_q,     rid_d;
    logic [1:0]                  rresp_q,   rresp_d;
    logic [C_WA_W-1:0]           r_addr_q,  r_addr_d;
    logic [7:0]                  r_len_q,   r_len_d;
    logic [1:0]                  r_burst_q, r_burst_d;
    logic [7:0]                  r_cnt_q,   r_cnt_d;

    logic                        ram_re;
    logic [C_WA_W-1:0]           ram_raddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata_q;

    // Read engine next-state: launch a RAM read on AR and on every non-final R beat.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        ram_re    = 1'b0;
        ram_raddr = f_next_addr(r_addr_q, r_len_q, r_burst_q);
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    ram_re    = 1'b1;
                    ram_raddr = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_LSB];
                    r_addr_d  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_LSB];
                    r_len_d   = S_AXI_ARLEN;
                    r_burst_d = S_AXI_ARBURST;
                    r_cnt_d   = 8'd0;
                    rid_d     = S_AXI_ARID;
                    rresp_d   = f_burst_ok(S_AXI_ARBURST, S_AXI_ARLEN) ? C_RESP_OKAY
                                                                       : C_RESP_SLVERR;
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // A stalled beat leaves the RAM output register untouched.
                if (S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        ram_re   = 1'b1;
                        r_addr_d = ram_raddr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
        endcase
    end

    // Read engine registers; reset aborts any burst in flight.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= C_RESP_OKAY;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM: byte-lane writes and a registered read-first port. Not reset so
    // contents survive ARESETN.
    // ------------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_DEPTH];

    // Byte-strobed write port plus synchronous read (old data on collision).
    always_ff @(posedge S_AXI_ACLK) begin
        for (int b = 0; b < C_STRB_W; b++) begin
            if (ram_we && S_AXI_WSTRB[b]) begin
                mem[w_addr_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_raddr];
        end
    end

    // Byte-offset address bits carry no information for a word-wide RAM.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[C_LSB-1:0], S_AXI_ARADDR[C_LSB-1:0]};

    // ------------------------------------------------------------------------
    // Outputs. RDATA is forced to zero outside a valid beat and for error bursts.
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = (rvalid_q && (rresp_q == C_RESP_OKAY)) ? ram_rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_ram_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_ram_burst
// Purpose  : Directed self-checking bench for axi_slave_ram_burst with
//            scoreboard queues for B responses and R beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_ram_burst;

    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;   logic [11:0] awaddr; logic [7:0] awlen; logic [1:0] awburst;
    logic        awvalid; logic awready;
    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast; logic wvalid; logic wready;
    logic [3:0]  bid;    logic [1:0] bresp; logic bvalid; logic bready;
    logic [3:0]  arid;   logic [11:0] araddr; logic [7:0] arlen; logic [1:0] arburst;
    logic        arvalid; logic arready;
    logic [3:0]  rid;    logic [31:0] rdata; logic [1:0] rresp; logic rlast;
    logic        rvalid; logic rready;

    always #5 clk = ~clk;

    axi_slave_ram_burst #(
        .C_S_AXI_ID_WIDTH  (4),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(12)
    ) dut (
        .S_AXI_ACLK   (clk),     .S_AXI_ARESETN(aresetn),
        .S_AXI_AWID   (awid),    .S_AXI_AWADDR (awaddr),  .S_AXI_AWLEN(awlen),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),   .S_AXI_WSTRB  (wstrb),   .S_AXI_WLAST(wlast),
        .S_AXI_WVALID (wvalid),  .S_AXI_WREADY (wready),
        .S_AXI_BID    (bid),     .S_AXI_BRESP  (bresp),   .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARID   (arid),    .S_AXI_ARADDR (araddr),  .S_AXI_ARLEN(arlen),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID    (rid),     .S_AXI_RDATA  (rdata),   .S_AXI_RRESP(rresp),
        .S_AXI_RLAST  (rlast),   .S_AXI_RVALID (rvalid),  .S_AXI_RREADY(rready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] data;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      r_q[$];
    bexp_t       b_q[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [1:0] resp,
                          input logic last, input logic [31:0] data);
        rbeat_t e;
        e.id = id; e.resp = resp; e.last = last; e.data = data;
        r_q.push_back(e);
    endtask

    // All channel tasks start and end 1ns after a rising edge.
    task automatic send_aw(input logic [3:0] id, input logic [11:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < LIMIT) begin @(negedge clk); n++; end
        chk("aw_wait", 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("wready_after_aw", 32'(wready), 32'd1);
        chk("awready_after_aw", 32'(awready), 32'd0);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < LIMIT) begin @(negedge clk); n++; end
        chk("w_wait", 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic recv_b();
        int    n = 0;
        bexp_t e;
        while (!bvalid && n < LIMIT) begin @(posedge clk); #1; n++; end
        chk("b_latency", n, 32'd0);
        chk("b_expected_pending", 32'(b_q.size() > 0), 32'd1);
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            chk("bid", 32'(bid), 32'(e.id));
            chk("bresp", 32'(bresp), 32'(e.resp));
        end
        @(posedge clk); #1;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        chk("awready_back", 32'(awready), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [11:0] addr, input int len,
                            input logic [1:0] burst, input int bad_beat, input logic [1:0] resp);
        bexp_t e;
        e.id = id; e.resp = resp;
        b_q.push_back(e);
        send_aw(id, addr, 8'(len), burst);
        for (int i = 0; i <= len; i++) begin
            send_w(wd[i], ws[i], ((i == len) != (i == bad_beat)));
        end
        recv_b();
        @(posedge clk); #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [11:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < LIMIT) begin @(negedge clk); n++; end
        chk("ar_wait", 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("arready_after_ar", 32'(arready), 32'd0);
    endtask

    // Consumes R beats against the scoreboard; stall=1 drives RREADY 1,0,0,1,...
    task automatic recv_r(input int beats, input bit stall);
        int     got = 0;
        int     c   = 0;
        rbeat_t e;
        while (got < beats && c < 2 * LIMIT) begin
            rready = stall ? ((c % 4) != 1 && (c % 4) != 2) : 1'b1;
            if (c == 0) chk("rvalid_latency", 32'(rvalid), 32'd1);
            if (rvalid && r_q.size() > 0) begin
                e = r_q[0];
                if (rready) begin
                    void'(r_q.pop_front());
                    got++;
                    chk("rdata", rdata, e.data);
                    chk("rresp", 32'(rresp), 32'(e.resp));
                    chk("rlast", 32'(rlast), 32'(e.last));
                    chk("rid", 32'(rid), 32'(e.id));
                end else begin
                    chk("rdata_hold", rdata, e.data);
                    chk("rlast_hold", 32'(rlast), 32'(e.last));
                end
            end
            @(posedge clk); #1;
            c++;
        end
        chk("r_beats", got, beats);
        chk("rvalid_drop", 32'(rvalid), 32'd0);
        chk("arready_back", 32'(arready), 32'd1);
        rready = 1'b1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [11:0] addr, input int len,
                           input logic [1:0] burst, input bit stall);
        send_ar(id, addr, 8'(len), burst);
        recv_r(len + 1, stall);
        @(posedge clk); #1;
    endtask

    // Safety net in case a task bound is ever bypassed.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_bid",     32'(bid),     32'd0);
        chk("rst_rid",     32'(rid),     32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // INCR write of four words at 0x010 then readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(4'h5, 12'h010, 3, 2'b01, -1, 2'b00);
        for (int i = 0; i < 4; i++) push_r(4'h3, 2'b00, i == 3, 32'hA0 + i);
        do_read(4'h3, 12'h010, 3, 2'b01, 1'b0);

        // Byte strobes merge into existing word
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(4'h1, 12'h040, 0, 2'b01, -1, 2'b00);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0101;
        do_write(4'h2, 12'h040, 0, 2'b01, -1, 2'b00);
        push_r(4'h4, 2'b00, 1'b1, 32'h12FF56FF);
        do_read(4'h4, 12'h040, 0, 2'b01, 1'b0);

        // WRAP read from word 6, len 3: words 6,7,4,5
        push_r(4'h7, 2'b00, 1'b0, 32'hA2);
        push_r(4'h7, 2'b00, 1'b0, 32'hA3);
        push_r(4'h7, 2'b00, 1'b0, 32'hA0);
        push_r(4'h7, 2'b00, 1'b1, 32'hA1);
        do_read(4'h7, 12'h018, 3, 2'b10, 1'b0);

        // FIXED write keeps only the last beat
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
        for (int i = 0; i < 3; i++) ws[i] = 4'hF;
        do_write(4'h6, 12'h080, 2, 2'b00, -1, 2'b00);
        push_r(4'h6, 2'b00, 1'b1, 32'h33);
        do_read(4'h6, 12'h080, 0, 2'b01, 1'b0);

        // len 7 read with RREADY stalls
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        do_write(4'h8, 12'h100, 7, 2'b01, -1, 2'b00);
        for (int i = 0; i < 8; i++) push_r(4'h9, 2'b00, i == 7, 32'hB0 + i);
        do_read(4'h9, 12'h100, 7, 2'b01, 1'b1);

        // Reserved AWBURST: SLVERR, memory untouched
        wd[0] = 32'hDEAD0000; wd[1] = 32'hDEAD0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'hC, 12'h010, 1, 2'b11, -1, 2'b10);
        push_r(4'hD, 2'b00, 1'b0, 32'hA0);
        push_r(4'hD, 2'b00, 1'b1, 32'hA1);
        do_read(4'hD, 12'h010, 1, 2'b01, 1'b0);

        // Illegal WRAP length read: SLVERR and zero data on every beat
        for (int i = 0; i < 3; i++) push_r(4'h1, 2'b10, i == 2, 32'h0);
        do_read(4'h1, 12'h010, 2, 2'b10, 1'b0);

        // Early WLAST: SLVERR but data still written
        wd[0] = 32'h5A5A0000; wd[1] = 32'h5A5A0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'hE, 12'h0C0, 1, 2'b01, 0, 2'b10);
        push_r(4'hE, 2'b00, 1'b0, 32'h5A5A0000);
        push_r(4'hE, 2'b00, 1'b1, 32'h5A5A0001);
        do_read(4'hE, 12'h0C0, 1, 2'b01, 1'b0);

        // INCR wraps from the top word to word 0
        wd[0] = 32'hD0; wd[1] = 32'hD1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'hF, 12'hFFC, 1, 2'b01, -1, 2'b00);
        push_r(4'h2, 2'b00, 1'b1, 32'hD1);
        do_read(4'h2, 12'h000, 0, 2'b01, 1'b0);
        push_r(4'h2, 2'b00, 1'b0, 32'hD0);
        push_r(4'h2, 2'b00, 1'b1, 32'hD1);
        do_read(4'h2, 12'hFFC, 1, 2'b01, 1'b0);

        // Reset in the middle of a 4-beat write after two beats
        send_aw(4'hA, 12'h200, 8'd3, 2'b01);
        send_w(32'hAA, 4'hF, 1'b0);
        send_w(32'hBB, 4'hF, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        chk("abort_wready",  32'(wready),  32'd0);
        chk("abort_awready", 32'(awready), 32'd1);
        chk("abort_bvalid",  32'(bvalid),  32'd0);
        chk("abort_arready", 32'(arready), 32'd1);
        chk("abort_bid",     32'(bid),     32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_b_after_abort", 32'(bvalid), 32'd0);
        end
        wd[0] = 32'hC0; wd[1] = 32'hC1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'h3, 12'h200, 1, 2'b01, -1, 2'b00);
        push_r(4'h5, 2'b00, 1'b0, 32'hC0);
        push_r(4'h5, 2'b00, 1'b1, 32'hC1);
        do_read(4'h5, 12'h200, 1, 2'b01, 1'b0);

        chk("r_queue_empty", 32'(r_q.size()), 32'd0);
        chk("b_queue_empty", 32'(b_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
